// File: rtl/multiplier_controller_pkg.sv
// multiplier_controller_pkg: shared state encoding, sizing and strobe
// bundle for the MSB-first shift-and-add multiplier.
package multiplier_controller_pkg;
   localparam int N_BITS = 8;
   localparam int CNT_W  = 3;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_ADD   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;
   typedef struct packed {
      logic load_v1;
      logic shift_v1;
      logic load_acc;
      logic shift_acc;
      logic count;
      logic select_acc;
   } strobes_t;
   localparam strobes_t STB_INIT  = 6'b101001;
   localparam strobes_t STB_SHIFT = 6'b000100;
   localparam strobes_t STB_ADD   = 6'b011010;
endpackage

// File: rtl/multiplier_controller_counter.sv
// Counter: loadable up-counter, used for both the datapath iteration count
// and the controller's shadow count.
module Counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         count,
   output logic [W-1:0] q
);
   always_ff @(posedge clk)
      if (!rst) q <= '0;
      else if (load) q <= din;
      else if (count) q <= q + 1'b1;
endmodule

// File: rtl/multiplier_datapath.sv
// MultiplierDataPath: V1 shift register, accumulator and iteration counter
// for an MSB-first shift-and-add multiply. v2 is not registered.
module MultiplierDataPath
   import multiplier_controller_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_BITS-1:0]     v1,
   input  logic [N_BITS-1:0]     v2,
   input  logic                  loadV1,
   input  logic                  shiftV1,
   input  logic                  loadAccumulated,
   input  logic                  shiftAccumulated,
   input  logic                  count,
   input  logic                  selectAccumulated,
   output logic                  co,
   output logic [2*N_BITS-1:0]   out
);
   logic [N_BITS-1:0] v1_reg;
   logic [CNT_W-1:0]  cnt;
   logic [2*N_BITS-1:0] addend;
   assign addend = v1_reg[N_BITS-1] ? {{N_BITS{1'b0}}, v2} : '0;
   always_ff @(posedge clk)
      if (!rst) v1_reg <= '0;
      else if (loadV1) v1_reg <= v1;
      else if (shiftV1) v1_reg <= v1_reg << 1;
   always_ff @(posedge clk)
      if (!rst) out <= '0;
      else if (loadAccumulated) out <= selectAccumulated ? '0 : out + addend;
      else if (shiftAccumulated) out <= out << 1;
   Counter #(.W(CNT_W)) u_cnt (
      .clk(clk), .rst(rst), .load(1'b0), .din('0), .count(count), .q(cnt)
   );
   assign co = &cnt;
endmodule

// File: rtl/multiplier_top.sv
// multiplier_top: controller wired to its datapath.
module multiplier_top
   import multiplier_controller_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [N_BITS-1:0]   v1,
   input  logic [N_BITS-1:0]   v2,
   output logic [2*N_BITS-1:0] out,
   output logic                ready,
   output logic                busy,
   output logic                done,
   output logic                err
);
   logic co, load_v1, shift_v1, load_acc, shift_acc, cnt, sel_acc;
   multiplier_controller u_ctrl (
      .clk(clk), .rst(rst), .start(start), .co(co),
      .ready(ready), .busy(busy), .done(done), .err(err),
      .loadV1(load_v1), .shiftV1(shift_v1), .loadAccumulated(load_acc),
      .shiftAccumulated(shift_acc), .count(cnt), .selectAccumulated(sel_acc)
   );
   MultiplierDataPath u_dp (
      .clk(clk), .rst(rst), .v1(v1), .v2(v2),
      .loadV1(load_v1), .shiftV1(shift_v1), .loadAccumulated(load_acc),
      .shiftAccumulated(shift_acc), .count(cnt), .selectAccumulated(sel_acc),
      .co(co), .out(out)
   );
endmodule

// File: rtl/multiplier_controller.sv
// multiplier_controller: Moore FSM sequencing MultiplierDataPath through one
// multiply, with a shadow iteration count to catch counter desync.
module multiplier_controller
   import multiplier_controller_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic co,
   output logic ready,
   output logic busy,
   output logic done,
   output logic err,
   output logic loadV1,
   output logic shiftV1,
   output logic loadAccumulated,
   output logic shiftAccumulated,
   output logic count,
   output logic selectAccumulated
);
   logic [2:0]       state, state_n;
   logic [CNT_W-1:0] shadow;
   logic             last;
   strobes_t         stb;
   Counter #(.W(CNT_W)) u_shadow (
      .clk(clk), .rst(rst), .load(1'b0), .din('0), .count(state == S_ADD), .q(shadow)
   );
   assign last = shadow == CNT_W'(N_BITS - 1);
   // ADD exits on the live co; any disagreement with the shadow is an error
   always_comb
      state_n = state == S_IDLE  ? (start ? S_INIT : S_IDLE)
              : state == S_INIT  ? S_SHIFT
              : state == S_SHIFT ? S_ADD
              : state == S_ADD   ? (co != last ? S_ERR : co ? S_DONE : S_SHIFT)
              : S_IDLE;
   always_ff @(posedge clk)
      state <= !rst ? S_IDLE : state_n;
   assign stb = state == S_INIT  ? STB_INIT
              : state == S_SHIFT ? STB_SHIFT
              : state == S_ADD   ? STB_ADD
              : '0;
   assign {loadV1, shiftV1, loadAccumulated, shiftAccumulated, count, selectAccumulated} = stb;
   assign ready = state == S_IDLE;
   assign busy  = state == S_INIT || state == S_SHIFT || state == S_ADD;
   assign done  = state == S_DONE;
   assign err   = state == S_ERR;
endmodule

// File: tb/tb_multiplier_controller.sv
// tb_multiplier_controller: vector table plus random operands against a
// cycle-phase timing table and integer-product model.
module tb_multiplier_controller;
   import multiplier_controller_pkg::*;
   logic clk = 0, rst = 0, start = 0, force_co = 0;
   logic [7:0] v1 = 0, v2 = 0;
   logic co, co_dp, ready, busy, done, err;
   logic loadV1, shiftV1, loadAccumulated, shiftAccumulated, count, selectAccumulated;
   logic [15:0] out, top_out;
   logic top_ready, top_busy, top_done, top_err;
   logic [5:0] stb_vec;
   logic [3:0] sts_vec;
   int checks = 0, errors = 0;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      int          x1;
      int          x2;
   } vec_t;
   vec_t tbl[5];

   always #5 clk = ~clk;
   assign co = force_co | co_dp;
   assign stb_vec = {loadV1, shiftV1, loadAccumulated, shiftAccumulated, count, selectAccumulated};
   assign sts_vec = {ready, busy, done, err};

   multiplier_controller u_dut (
      .clk(clk), .rst(rst), .start(start), .co(co),
      .ready(ready), .busy(busy), .done(done), .err(err),
      .loadV1(loadV1), .shiftV1(shiftV1), .loadAccumulated(loadAccumulated),
      .shiftAccumulated(shiftAccumulated), .count(count), .selectAccumulated(selectAccumulated)
   );
   MultiplierDataPath u_dp (
      .clk(clk), .rst(rst), .v1(v1), .v2(v2),
      .loadV1(loadV1), .shiftV1(shiftV1), .loadAccumulated(loadAccumulated),
      .shiftAccumulated(shiftAccumulated), .count(count), .selectAccumulated(selectAccumulated),
      .co(co_dp), .out(out)
   );
   multiplier_top u_top (
      .clk(clk), .rst(rst), .start(start), .v1(v1), .v2(v2), .out(top_out),
      .ready(top_ready), .busy(top_busy), .done(top_done), .err(top_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // Strobes expected k cycles after start was sampled: INIT, 8 x (SHIFT, ADD), DONE, IDLE
   function automatic logic [5:0] exp_stb(input int k);
      return k == 1 ? 6'b101001 : (k >= 2 && k <= 17) ? (k % 2 == 0 ? 6'b000100 : 6'b011010) : 6'b000000;
   endfunction

   function automatic logic [3:0] exp_sts(input int k);
      return k <= 17 ? 4'b0100 : k == 18 ? 4'b0010 : 4'b1000;
   endfunction

   // Entered and left at a negedge in an IDLE cycle, so calls chain back-to-back
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p, input int x1, input int x2);
      int n_cnt, n_done;
      n_cnt = 0;
      n_done = 0;
      v1 = a;
      v2 = b;
      start = 1;
      chk("ready_at_start", 32'(ready), 32'd1);
      @(negedge clk);
      for (int k = 1; k <= 19; k++) begin
         start = (k == x1 || k == x2);
         chk($sformatf("strobes_c%0d", k), 32'(stb_vec), 32'(exp_stb(k)));
         chk($sformatf("status_c%0d", k), 32'(sts_vec), 32'(exp_sts(k)));
         n_cnt += int'(count);
         n_done += int'(done);
         if (k == 18) begin
            chk("product", 32'(out), 32'(p));
            chk("top_product", {15'd0, top_done, top_out}, {15'd0, 1'b1, p});
         end
         if (k < 19) @(negedge clk);
      end
      start = 0;
      chk("count_pulses", n_cnt, 8);
      chk("done_pulses", n_done, 1);
      chk("shadow_end", 32'(u_dut.shadow), 32'd0);
   endtask

   initial begin
      int n_done;
      logic [7:0] a, b;
      tbl[0] = '{8'd13,   8'd11,  16'h008F, -1, -1};
      tbl[1] = '{8'd255,  8'd255, 16'hFE01, -1, -1};
      tbl[2] = '{8'd0,    8'd200, 16'h0000, -1, -1};
      tbl[3] = '{8'h80,   8'h03,  16'h0180, -1, -1};
      tbl[4] = '{8'h5A,   8'h3C,  16'h1518,  5, 18};

      repeat (2) @(negedge clk);
      chk("reset_status", 32'(sts_vec), 32'b1000);
      chk("reset_strobes", 32'(stb_vec), 32'd0);
      chk("reset_shadow", 32'(u_dut.shadow), 32'd0);
      rst = 1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) do_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].x1, tbl[i].x2);

      // reset sampled at edge 9 of an operation
      v1 = 8'd9;
      v2 = 8'd9;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (8) @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("midreset_status", 32'(sts_vec), 32'b1000);
      chk("midreset_strobes", 32'(stb_vec), 32'd0);
      chk("midreset_shadow", 32'(u_dut.shadow), 32'd0);
      rst = 1;
      do_op(8'd7, 8'd6, 16'h002A, -1, -1);

      // co forced early at the third ADD
      v1 = 8'd13;
      v2 = 8'd11;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (6) @(negedge clk);
      chk("third_add_strobes", 32'(stb_vec), 32'b011010);
      force_co = 1;
      @(negedge clk);
      force_co = 0;
      chk("err_pulse", 32'(sts_vec), 32'b0001);
      chk("err_strobes", 32'(stb_vec), 32'd0);
      @(negedge clk);
      chk("after_err", 32'(sts_vec), 32'b1000);
      n_done = 0;
      for (int k = 0; k < 12; k++) begin
         n_done += int'(done) + int'(err);
         @(negedge clk);
      end
      chk("no_done_after_err", n_done, 0);
      rst = 0;
      @(negedge clk);
      rst = 1;

      for (int i = 0; i < 20; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         do_op(a, b, 16'(int'(a) * int'(b)), -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/multiplier_controller.md
Name: multiplier_controller

Overview:
- FSM that sequences MultiplierDataPath through one 8-bit × 8-bit MSB-first shift-and-add multiply per request.
- Drives the six datapath strobes and watches the datapath 3-bit counter carry (co).
- Gives requesters a start/ready/busy/done interface.
- Keeps an internal shadow iteration count and flags an error if the datapath counter falls out of step.

Parameters:
- N_BITS, 8, multiplier iterations per operation; must equal 2^(datapath counter width).
- CNT_W, 3, width of the shadow iteration counter; N_BITS = 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk only
- start  input  1  request; accepted only when ready=1
- co  input  1  datapath counter carry; high when the datapath counter = N_BITS-1
- ready  output  1  high in IDLE only
- busy  output  1  high in INIT, SHIFT, ADD
- done  output  1  one-cycle pulse; datapath out holds a valid product
- err  output  1  one-cycle pulse on shadow/datapath counter mismatch
- loadV1  output  1  load V1 shift register
- shiftV1  output  1  shift V1 left
- loadAccumulated  output  1  load accumulator
- shiftAccumulated  output  1  shift accumulator left
- count  output  1  increment datapath counter
- selectAccumulated  output  1  1 = accumulator input is zero (clear); 0 = adder output

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, shadow=0, done=err=0, all strobes 0, ready=1 from the next cycle. The shared rst also zeroes the datapath counter. Reset wins over every other event, including mid-operation.
- All strobes decode from the registered state (Moore), with one exception: the ADD exit decision uses the live co.
- Strobes not listed for a state are 0.
- IDLE:
  - ready=1.
  - start=1 → INIT.
- INIT (1 cycle):
  - loadV1=1, loadAccumulated=1, selectAccumulated=1. This captures v1 and clears the accumulator.
  - → SHIFT.
- SHIFT (1 cycle):
  - shiftAccumulated=1.
  - → ADD.
- ADD (1 cycle):
  - loadAccumulated=1, selectAccumulated=0, shiftV1=1, count=1. The adder adds v2 if the V1 MSB is 1.
  - Shadow increments mod N_BITS.
  - co=1 and shadow=N_BITS-1 → DONE.
  - co=0 and shadow≠N_BITS-1 → SHIFT.
  - Mismatch (co=1 and shadow≠N_BITS-1, or co=0 and shadow=N_BITS-1) → ERR.
- DONE (1 cycle):
  - done=1, all strobes 0.
  - → IDLE. start in DONE is ignored.
- ERR (1 cycle):
  - err=1, all strobes 0.
  - → IDLE. The datapath counter is not repaired; only rst realigns it.
- Latency:
  - start sampled at edge 0 → INIT at cycle 1, SHIFT/ADD pairs at cycles 2..17, DONE at cycle 18.
  - ready returns at cycle 19.
  - Minimum start-to-start spacing is 19 cycles.
- The first SHIFT acts on a zero accumulator and is harmless.
- Product = v1*v2 mod 2^16 (exact, no overflow for 8-bit operands).
- After 8 ADDs the datapath counter wraps back to 0, so the next operation needs no counter reload.
- Requester obligations:
  - v1 must be valid in the INIT cycle.
  - v2 must be held stable from INIT through the last ADD; the datapath does not register v2.
- start while busy or in DONE/ERR is dropped, not queued.
- Datapath out is left untouched after DONE/ERR until the next INIT.

Decomposition:
- Shared package: state encoding constants (IDLE, INIT, SHIFT, ADD, DONE, ERR; 3-bit, binary), N_BITS, CNT_W.
- One natural sub-module: the existing Counter #(CNT_W) reused as the shadow counter. Its load is tied low; count=(state==ADD).
- Add a top-level wrapper, multiplier_top, that connects multiplier_controller to MultiplierDataPath.

Test Plan:
- Reset, then v1=13, v2=11, start pulse at cycle 0 → done pulse at cycle 18, out=0x008F, err stays 0, ready=1 at cycle 19.
- v1=255, v2=255 → out=0xFE01. Then back-to-back v1=0, v2=200 with start at the first ready cycle → out=0x0000 at the second done.
- Extra start pulses at cycles 5 and 18 during an operation → ignored. Exactly one done; strobe trace unchanged; shadow ends at 0.
- rst=0 at cycle 9 mid-operation → next cycle state IDLE, strobes 0, done=0. Then v1=7, v2=6 → out=0x002A at done.
- Force co=1 at the third ADD cycle (bench override) → err pulse the next cycle, then IDLE, no done.
- Strobe check per cycle for v1=0x80, v2=0x03 → loadV1 only in INIT; exactly 8 count pulses; out=0x0180.
